// File: rtl/pio_master.sv
// PIO bus initiator: issues one reg_bs/reg_rd/reg_wr transaction at a time, waits for
// pio_ack / pio_rvalid with a timeout, returns a response and keeps txn/timeout counters.
module pio_master #(
  parameter int PIO_NBITS     = 32,
  parameter int TIMEOUT_NBITS = 10,
  parameter int STAT_NBITS    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [PIO_NBITS-1:0]  cmd_addr_i,
  input  logic [PIO_NBITS-1:0]  cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [PIO_NBITS-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  reg_bs_o,
  output logic                  reg_rd_o,
  output logic                  reg_wr_o,
  output logic [PIO_NBITS-1:0]  reg_addr_o,
  output logic [PIO_NBITS-1:0]  reg_din_o,
  input  logic                  pio_ack_i,
  input  logic                  pio_rvalid_i,
  input  logic [PIO_NBITS-1:0]  pio_rdata_i,
  output logic [STAT_NBITS-1:0] txn_count_o,
  output logic [STAT_NBITS-1:0] timeout_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

  state_e                   state_q;
  logic                     wr_q;
  logic                     cmd_ready_q;
  logic                     rsp_valid_q;
  logic                     rsp_err_q;
  logic [PIO_NBITS-1:0]     rsp_rdata_q;
  logic                     reg_bs_q;
  logic                     reg_rd_q;
  logic                     reg_wr_q;
  logic [PIO_NBITS-1:0]     reg_addr_q;
  logic [PIO_NBITS-1:0]     reg_din_q;
  logic [TIMEOUT_NBITS-1:0] wait_cnt_q;
  logic [TIMEOUT_NBITS-1:0] wait_cnt_d;
  logic [STAT_NBITS-1:0]    txn_cnt_q;
  logic [STAT_NBITS-1:0]    tmo_cnt_q;
  logic                     done;
  logic                     timeout;

  // Only the completion signal matching the pending command type counts. The timeout
  // fires in the WAIT cycle where the counter would reach all-ones.
  always_comb begin
    wait_cnt_d = wait_cnt_q + TIMEOUT_NBITS'(1);
    done       = wr_q ? pio_ack_i : pio_rvalid_i;
    timeout    = &wait_cnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      reg_bs_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
      wait_cnt_q  <= '0;
      txn_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      reg_bs_q <= 1'b0;
      reg_rd_q <= 1'b0;
      reg_wr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            wr_q        <= cmd_wr_i;
            reg_addr_q  <= cmd_addr_i;
            reg_din_q   <= cmd_wdata_i;
            reg_bs_q    <= 1'b1;
            reg_rd_q    <= ~cmd_wr_i;
            reg_wr_q    <= cmd_wr_i;
            cmd_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (done || timeout) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~done;
            if (done) rsp_rdata_q <= wr_q ? '0 : pio_rdata_i;
            else      rsp_rdata_q <= '1;
            txn_cnt_q <= txn_cnt_q + STAT_NBITS'(1);
            if (!done && !(&tmo_cnt_q)) tmo_cnt_q <= tmo_cnt_q + STAT_NBITS'(1);
            state_q <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Slave levels only update on their divided clock; wait out any stale ack/rvalid.
          if (!pio_ack_i && !pio_rvalid_i) begin
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign reg_bs_o        = reg_bs_q;
  assign reg_rd_o        = reg_rd_q;
  assign reg_wr_o        = reg_wr_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_din_o       = reg_din_q;
  assign txn_count_o     = txn_cnt_q;
  assign timeout_count_o = tmo_cnt_q;

endmodule
